pll_nco: RTL and testbench

- Numerically controlled oscillator stage of the all-digital PLL, directly downstream of the PI loop filter.
- Consumes the filter's signed 16-bit control word and converts it to a clamped frequency control word (FCW).
- Runs a phase accumulator, emits the DCO square wave, and emits a divided feedback clock that returns to the phase detector's up/down logic.

---
 rtl/pll_nco_if.sv | 30 +++
 rtl/pll_nco.sv | 130 +++++++++++++
 tb/tb_pll_nco.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/pll_nco_if.sv
// pll_nco_if: control/observation bundle for the NCO stage.
//   en         - accumulator run enable (driven by master)
//   ctrl       - signed 16-bit loop-filter control word (driven by master)
//   fcw        - registered, clamped frequency control word
//   sat_hi/lo  - registered clamp flags
//   dco_out    - DCO square wave (accumulator MSB)
//   wrap_pulse - one-cycle pulse per accumulator overflow
//   fb_out     - divided feedback clock toward the phase detector
interface pll_nco_if #(
    parameter int ACC_W = 32
);
    logic                    en;
    logic signed [15:0]      ctrl;
    logic        [ACC_W-1:0] fcw;
    logic                    sat_hi;
    logic                    sat_lo;
    logic                    dco_out;
    logic                    wrap_pulse;
    logic                    fb_out;

    modport master (
        output en, ctrl,
        input  fcw, sat_hi, sat_lo, dco_out, wrap_pulse, fb_out
    );

    modport slave (
        input  en, ctrl,
        output fcw, sat_hi, sat_lo, dco_out, wrap_pulse, fb_out
    );
endinterface

// File: rtl/pll_nco.sv
// pll_nco: numerically controlled oscillator of the all-digital PLL.
// Takes the loop filter's signed control word, turns it into a clamped
// frequency control word (FCW), runs a phase accumulator and produces the
// DCO square wave plus a divided feedback clock.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - pll_nco_if.slave (en, ctrl in; fcw, sat_hi, sat_lo, dco_out,
//           wrap_pulse, fb_out out)
module pll_nco #(
    parameter int               ACC_W      = 32,
    parameter logic [ACC_W-1:0] FCW_NOM    = 32'h0800_0000,
    parameter int               GAIN_SHIFT = 13,
    parameter logic [ACC_W-1:0] FCW_MIN    = 32'h0400_0000,
    parameter logic [ACC_W-1:0] FCW_MAX    = 32'h1000_0000,
    parameter int               DIV_N      = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    pll_nco_if.slave bus
);

    // Two guard bits above the accumulator width keep the signed sum of
    // the shifted control word and the nominal FCW free of overflow.
    localparam int UW      = ACC_W + 2;
    localparam int HALF    = DIV_N / 2;
    localparam int HC_W    = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(HALF - 1);

    // ---------------------------------------------------------------
    // Stage 1: control word capture (runs regardless of en)
    // ---------------------------------------------------------------
    logic signed [15:0] ctrl_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ctrl_q <= '0;
        else        ctrl_q <= bus.ctrl;
    end

    // ---------------------------------------------------------------
    // Stage 2: unclamped FCW, clamp and saturation flags
    // ---------------------------------------------------------------
    logic signed [UW-1:0] ctrl_ext;
    logic signed [UW-1:0] u_val;
    logic signed [UW-1:0] nom_s;
    logic signed [UW-1:0] min_s;
    logic signed [UW-1:0] max_s;
    logic                 over_max;
    logic                 under_min;
    logic [ACC_W-1:0]     fcw_nxt;

    assign ctrl_ext  = signed'({{(UW-16){ctrl_q[15]}}, ctrl_q});
    assign nom_s     = signed'({2'b00, FCW_NOM});
    assign min_s     = signed'({2'b00, FCW_MIN});
    assign max_s     = signed'({2'b00, FCW_MAX});
    assign u_val     = (ctrl_ext <<< GAIN_SHIFT) + nom_s;
    // Strict compares: landing exactly on a bound is not saturation.
    assign over_max  = (u_val > max_s);
    assign under_min = (u_val < min_s);

    always_comb begin
        fcw_nxt = u_val[ACC_W-1:0];
        if (over_max)       fcw_nxt = FCW_MAX;
        else if (under_min) fcw_nxt = FCW_MIN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.fcw    <= FCW_NOM;
            bus.sat_hi <= 1'b0;
            bus.sat_lo <= 1'b0;
        end else begin
            bus.fcw    <= fcw_nxt;
            bus.sat_hi <= over_max;
            bus.sat_lo <= under_min;
        end
    end

    // ---------------------------------------------------------------
    // Phase accumulator. The add always uses the FCW already sitting in
    // the output register, so a ctrl change reaches the phase two edges
    // after it is applied.
    // ---------------------------------------------------------------
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_nxt;
    logic             carry;

    always_comb begin
        {carry, acc_nxt} = {1'b0, acc} + {1'b0, bus.fcw};
        if (!bus.en) begin
            // Frozen phase: no advance and no overflow event.
            carry   = 1'b0;
            acc_nxt = acc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc            <= '0;
            bus.wrap_pulse <= 1'b0;
        end else begin
            acc            <= acc_nxt;
            bus.wrap_pulse <= carry;
        end
    end

    assign bus.dco_out = acc[ACC_W-1];

    // ---------------------------------------------------------------
    // Feedback divider: toggle fb_out every DIV_N/2 wraps so a full
    // feedback period spans DIV_N wraps. Toggle lands on the same edge
    // that raises wrap_pulse.
    // ---------------------------------------------------------------
    logic [HC_W-1:0] half_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half_cnt   <= '0;
            bus.fb_out <= 1'b0;
        end else if (carry) begin
            if (half_cnt == HC_LAST) begin
                half_cnt   <= '0;
                bus.fb_out <= ~bus.fb_out;
            end else begin
                half_cnt   <= half_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pll_nco.sv
// tb_pll_nco: self-checking bench for pll_nco. A behavioural model tracks
// the phase as an integer modulo 2^32, derives the FCW arithmetically from
// the control word applied two edges earlier, and derives fb_out from the
// total number of wraps since reset.
module tb_pll_nco;
    localparam longint TWO32 = 64'h1_0000_0000;
    localparam longint NOM   = 64'h0800_0000;
    localparam longint FMIN  = 64'h0400_0000;
    localparam longint FMAX  = 64'h1000_0000;
    localparam int     DIVN  = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pll_nco_if #(.ACC_W(32)) bus ();

    pll_nco dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // model state
    longint m_acc;
    int     m_wraps;
    bit     m_wrap;
    int     hist[$];     // ctrl seen at the last two edges, oldest first
    bit     cur_en;
    int     cur_ctrl;

    function automatic longint unclamped(int c);
        return longint'(c) * 8192 + NOM;
    endfunction

    function automatic longint fcw_of(int c);
        longint u = unclamped(c);
        if (u > FMAX) return FMAX;
        if (u < FMIN) return FMIN;
        return u;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_acc   = 0;
        m_wraps = 0;
        m_wrap  = 0;
        hist    = {0, 0};
    endtask

    task automatic model_edge();
        longint f = fcw_of(hist[0]);
        longint s;
        bit c = 0;
        if (cur_en) begin
            s     = m_acc + f;
            c     = (s >= TWO32);
            m_acc = s % TWO32;
        end
        m_wrap = c;
        if (c) m_wraps++;
        hist.push_back(cur_ctrl);
        void'(hist.pop_front());
    endtask

    task automatic check_all();
        check("fcw",        64'(bus.fcw),        64'(fcw_of(hist[0])));
        check("sat_hi",     64'(bus.sat_hi),     64'(unclamped(hist[0]) > FMAX));
        check("sat_lo",     64'(bus.sat_lo),     64'(unclamped(hist[0]) < FMIN));
        check("dco_out",    64'(bus.dco_out),    64'((m_acc >> 31) & 1));
        check("wrap_pulse", 64'(bus.wrap_pulse), 64'(m_wrap));
        check("fb_out",     64'(bus.fb_out),     64'((m_wraps / (DIVN / 2)) % 2));
    endtask

    task automatic drive(input bit e, input int c);
        cur_en   = e;
        cur_ctrl = c;
        bus.en   = e;
        bus.ctrl = 16'(c);
    endtask

    // one clock edge: advance the model, then sample 1 ns after the edge
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    // free-running from reset with ctrl=0: 8 wraps per 256 cycles, 32-cycle
    // spacing, first fb_out rise on the 4th wrap
    task automatic run_nominal(input string tag);
        int n_wrap = 0;
        int rise_at = -1;
        int last_w = -1;
        int spacing = -1;
        drive(1, 0);
        for (int i = 1; i <= 256; i++) begin
            tick();
            if (bus.wrap_pulse === 1'b1) begin
                n_wrap++;
                if (last_w >= 0) spacing = i - last_w;
                last_w = i;
                if (bus.fb_out === 1'b1 && rise_at < 0) rise_at = n_wrap;
            end
        end
        check({tag, "_wraps_256"}, 64'(n_wrap), 64'd8);
        check({tag, "_wrap_spacing"}, 64'(spacing), 64'd32);
        check({tag, "_fb_first_rise"}, 64'(rise_at), 64'd4);
        check({tag, "_fcw_nom"}, 64'(bus.fcw), 64'h0800_0000);
    endtask

    initial begin
        bit found;
        int c;
        drive(0, 0);
        model_reset();
        #12;
        check_all();
        check("reset_fcw", 64'(bus.fcw), 64'h0800_0000);

        @(negedge clk);
        rst_n = 1'b1;
        run_nominal("nom1");

        // ctrl steps and clamping, with 2-edge latency
        drive(1, 1);
        tick();
        check("lat1_fcw", 64'(bus.fcw), 64'h0800_0000);
        tick();
        check("p1_fcw", 64'(bus.fcw), 64'h0800_2000);
        drive(1, -1);
        tick(); tick();
        check("m1_fcw", 64'(bus.fcw), 64'h07FF_E000);
        drive(1, 32767);
        tick(); tick();
        check("max_fcw", 64'(bus.fcw), 64'h1000_0000);
        check("max_sat_hi", 64'(bus.sat_hi), 64'd1);
        drive(1, -32768);
        tick(); tick();
        check("min_fcw", 64'(bus.fcw), 64'h0400_0000);
        check("min_sat_lo", 64'(bus.sat_lo), 64'd1);
        drive(1, 0);
        tick();
        check("clr_lat_sat_lo", 64'(bus.sat_lo), 64'd1);
        tick();
        check("clr_sat", 64'({bus.sat_hi, bus.sat_lo}), 64'd0);
        // exact bounds are not saturation: ctrl*8192 = +0x0800_0000 / -0x0400_0000
        drive(1, 16384);
        tick(); tick();
        check("eq_max_sat_hi", 64'(bus.sat_hi), 64'd0);
        drive(1, -8192);
        tick(); tick();
        check("eq_min_sat_lo", 64'(bus.sat_lo), 64'd0);
        drive(1, 0);
        for (int i = 0; i < 45; i++) tick();

        // enable gap with a ctrl step inside it
        drive(0, 0);
        for (int i = 0; i < 20; i++) tick();
        drive(0, 1);
        for (int i = 0; i < 30; i++) tick();
        check("gap_fcw", 64'(bus.fcw), 64'h0800_2000);
        drive(1, 0);
        for (int i = 0; i < 100; i++) tick();

        // randomized control and enable
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0: c = 32767;
                    1: c = -32768;
                    2: c = 16384;
                    default: c = -8192;
                endcase
            end else begin
                c = int'($signed(16'($urandom)));
            end
            drive($urandom_range(0, 9) != 0, c);
            tick();
        end

        // async reset mid-cycle with fb_out high and phase nonzero
        drive(1, 0);
        found = 0;
        for (int i = 0; i < 600 && !found; i++) begin
            tick();
            if (((m_wraps / (DIVN / 2)) % 2) == 1 && m_acc != 0) found = 1;
        end
        check("rst_setup_found", 64'(found), 64'd1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        check("async_rst_fb", 64'(bus.fb_out), 64'd0);
        check("async_rst_dco", 64'(bus.dco_out), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_nominal("nom2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
